// File: rtl/pipo_ctrl_pkg.sv
// Shared definitions for the pipo load arbiter: FSM state encoding and the
// owner-index width helper.
package pipo_ctrl_pkg;

  // Controller states. The encoding is fixed so debug probes and bound
  // checkers can decode the exported state directly.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Width of an encoded requester index. Never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipo_load_arbiter_if.sv
// Requester and register-side bus of the pipo load arbiter.
//
// Handshake: requester i holds req_valid[i] and its word stable until it
// sees req_ready[i]; a word transfers on any rising edge where both
// req_valid[i] and req_ready[i] are high. req_ready is one-hot or zero.
// reg_load is a single-cycle strobe; reg_data/reg_owner stay stable from
// the load until the next transfer.
interface pipo_load_arbiter_if
  import pipo_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4
);
  localparam int OWNER_W = owner_w(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     reg_load;
  logic [WIDTH-1:0]         reg_data;
  logic [OWNER_W-1:0]       reg_owner;
  logic                     busy;
  state_t                   state;   // debug view of the controller FSM

  // Requester / register side.
  modport master (
    output req_valid, req_data,
    input  req_ready, reg_load, reg_data, reg_owner, busy, state
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data,
    output req_ready, reg_load, reg_data, reg_owner, busy, state
  );

endinterface

// File: rtl/pipo_load_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request found when
// scanning upward from ptr (with wrap-around) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OWNER_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [OWNER_W-1:0] grant_idx,
  output logic               grant_any
);

  int idx;

  // Scan from the pointer position and take the first valid request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = OWNER_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Shares one parallel-in/parallel-out register between NUM_REQ requesters.
// A round-robin winner is granted in IDLE, its word is strobed into the
// register in LOAD, and HOLD keeps the value stable for HOLD_CYCLES cycles.
module pipo_load_arbiter
  import pipo_ctrl_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset,
  pipo_load_arbiter_if.slave  bus
);

  localparam int OWNER_W = owner_w(NUM_REQ);
  localparam int CNT_W   = $clog2(HOLD_CYCLES + 2);

  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [OWNER_W-1:0] ptr;
  logic               reg_load_q;
  logic               busy_q;
  logic [WIDTH-1:0]   reg_data_q;
  logic [OWNER_W-1:0] reg_owner_q;

  logic [NUM_REQ-1:0] grant;
  logic [OWNER_W-1:0] grant_idx;
  logic               grant_any;
  logic               ready_en;
  logic               xfer;
  logic [WIDTH-1:0]   win_data;
  logic [OWNER_W-1:0] ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .OWNER_W (OWNER_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Grants are only offered while idle and never while reset is applied,
  // so no transfer can be claimed on a reset edge.
  always_comb begin
    ready_en = (state == ST_IDLE) && !reset;
    xfer     = ready_en && grant_any;
    win_data = bus.req_data[int'(grant_idx)*WIDTH +: WIDTH];
    ptr_next = (grant_idx == OWNER_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  assign bus.req_ready = ready_en ? grant : '0;
  assign bus.reg_load  = reg_load_q;
  assign bus.reg_data  = reg_data_q;
  assign bus.reg_owner = reg_owner_q;
  assign bus.busy      = busy_q;
  assign bus.state     = state;

  // Controller FSM with registered strobe, busy flag and captured word.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      ptr         <= '0;
      reg_load_q  <= 1'b0;
      busy_q      <= 1'b0;
      reg_data_q  <= '0;
      reg_owner_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          reg_load_q <= 1'b0;
          if (xfer) begin
            reg_data_q  <= win_data;
            reg_owner_q <= grant_idx;
            ptr         <= ptr_next;
            state       <= ST_LOAD;
            reg_load_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_LOAD: begin
          reg_load_q <= 1'b0;
          if (HOLD_CYCLES == 0) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            state    <= ST_HOLD;
            hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
            busy_q   <= 1'b1;
          end
        end
        ST_HOLD: begin
          reg_load_q <= 1'b0;
          if (hold_cnt == '0) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          reg_load_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Bench for pipo_load_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_pipo_load_arbiter;
  import pipo_ctrl_pkg::*;

  localparam int W    = 4;
  localparam int N    = 4;
  localparam int HOLD = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset0 = 1'b1;
  logic reset1 = 1'b1;

  pipo_load_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus0();
  pipo_load_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus1();

  pipo_load_arbiter #(.WIDTH(W), .NUM_REQ(N), .HOLD_CYCLES(HOLD)) u_dut0 (
    .clock (clock),
    .reset (reset0),
    .bus   (bus0)
  );

  pipo_load_arbiter #(.WIDTH(W), .NUM_REQ(N), .HOLD_CYCLES(0)) u_dut1 (
    .clock (clock),
    .reset (reset1),
    .bus   (bus1)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // m_wait counts cycles until the next arbitration is allowed (0 = can grant).
  int         m_ptr  = 0;
  int         m_wait = 0;
  logic       m_load = 1'b0;
  logic [W-1:0] m_data = '0;
  int         m_owner = 0;
  logic [N-1:0] exp_ready;

  function automatic int model_winner(input logic [N-1:0] v);
    for (int j = 0; j < N; j++)
      if (v[(m_ptr + j) % N]) return (m_ptr + j) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready(input logic [N-1:0] v);
    int w;
    w = model_winner(v);
    if (reset0 || m_wait != 0 || w < 0) return '0;
    return N'(1) << w;
  endfunction

  // Advance the model across one rising edge, then let the DUT take it.
  task automatic advance();
    int w;
    logic [N*W-1:0] d;
    w = model_winner(bus0.req_valid);
    d = bus0.req_data;
    if (reset0) begin
      m_ptr = 0; m_wait = 0; m_load = 1'b0; m_data = '0; m_owner = 0;
    end else if (m_wait == 0 && w >= 0) begin
      m_load  = 1'b1;
      m_data  = d[w*W +: W];
      m_owner = w;
      m_wait  = 1 + HOLD;
      m_ptr   = (w + 1) % N;
    end else begin
      m_load = 1'b0;
      if (m_wait > 0) m_wait--;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset0 = 1'b1;
    bus0.req_valid = '0;
    advance();
    reset0 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset0 = 1'b1;
    bus0.req_valid = '1;
    bus0.req_data  = N*W'($urandom);
    advance();
    advance();
    @(negedge clock);
    n_vec++; if (bus0.reg_load !== 1'b0) begin n_err++; $display("FAIL reset_load: got %b want 0", bus0.reg_load); end
    n_vec++; if (bus0.req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", bus0.req_ready); end
    n_vec++; if (bus0.reg_data !== '0) begin n_err++; $display("FAIL reset_data: got %b want 0000", bus0.reg_data); end
    n_vec++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
    n_vec++; if (bus0.reg_owner !== '0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", bus0.reg_owner); end
    bus0.req_valid = '0;
    reset0 = 1'b0;
    advance();
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    do_reset();
    bus0.req_valid = 4'b0100;
    bus0.req_data  = {4'h0, 4'b1010, 4'h0, 4'h0};
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      exp_ready = model_ready(bus0.req_valid);
      if (bus0.busy === 1'b1) busy_cnt++;
      n_vec++; if (bus0.req_ready !== exp_ready) begin n_err++; $display("FAIL single_ready c%0d: got %b want %b", c, bus0.req_ready, exp_ready); end
      n_vec++; if (bus0.reg_load !== m_load) begin n_err++; $display("FAIL single_load c%0d: got %b want %b", c, bus0.reg_load, m_load); end
      n_vec++; if (bus0.reg_data !== m_data) begin n_err++; $display("FAIL single_data c%0d: got %b want %b", c, bus0.reg_data, m_data); end
      n_vec++; if (bus0.reg_owner !== 2'(m_owner)) begin n_err++; $display("FAIL single_owner c%0d: got %0d want %0d", c, bus0.reg_owner, m_owner); end
      n_vec++; if (bus0.busy !== (m_wait != 0)) begin n_err++; $display("FAIL single_busy c%0d: got %b want %b", c, bus0.busy, (m_wait != 0)); end
      if (c == 1) begin
        n_vec++; if (bus0.reg_data !== 4'b1010 || bus0.reg_owner !== 2'd2) begin n_err++; $display("FAIL single_word: got %b/%0d want 1010/2", bus0.reg_data, bus0.reg_owner); end
      end
      advance();
      if (exp_ready != '0) bus0.req_valid = '0;
    end
    n_vec++; if (busy_cnt != 1 + HOLD) begin n_err++; $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, 1 + HOLD); end
  endtask

  task automatic test_contention();
    int last = -1;
    logic [W-1:0] want;
    do_reset();
    bus0.req_valid = '1;
    bus0.req_data  = {4'b0101, 4'b0011, 4'b1100, 4'b1010};
    exp_q = {4'b1010, 4'b1100, 4'b0011, 4'b0101, 4'b1010};
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      exp_ready = model_ready(bus0.req_valid);
      n_vec++; if (bus0.req_ready !== exp_ready) begin n_err++; $display("FAIL cont_ready c%0d: got %b want %b", c, bus0.req_ready, exp_ready); end
      n_vec++; if (bus0.reg_load !== m_load) begin n_err++; $display("FAIL cont_load c%0d: got %b want %b", c, bus0.reg_load, m_load); end
      n_vec++; if (bus0.reg_owner !== 2'(m_owner)) begin n_err++; $display("FAIL cont_owner c%0d: got %0d want %0d", c, bus0.reg_owner, m_owner); end
      if (bus0.reg_load === 1'b1) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_vec++; if (bus0.reg_data !== want) begin n_err++; $display("FAIL cont_order c%0d: got %b want %b", c, bus0.reg_data, want); end
        if (last >= 0) begin
          n_vec++; if (c - last != 2 + HOLD) begin n_err++; $display("FAIL cont_spacing: got %0d want %0d", c - last, 2 + HOLD); end
        end
        last = c;
      end
      advance();
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL cont_count: got %0d pending want 0", exp_q.size()); end
    bus0.req_valid = '0;
  endtask

  task automatic test_late_arrival();
    do_reset();
    bus0.req_valid = 4'b1000;
    bus0.req_data  = {4'b0101, 4'b0011, 4'b1100, 4'b1010};
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      exp_ready = model_ready(bus0.req_valid);
      n_vec++; if (bus0.req_ready !== exp_ready) begin n_err++; $display("FAIL late_ready c%0d: got %b want %b", c, bus0.req_ready, exp_ready); end
      n_vec++; if (bus0.reg_load !== m_load) begin n_err++; $display("FAIL late_load c%0d: got %b want %b", c, bus0.reg_load, m_load); end
      n_vec++; if (bus0.reg_data !== m_data) begin n_err++; $display("FAIL late_data c%0d: got %b want %b", c, bus0.reg_data, m_data); end
      n_vec++; if (bus0.busy !== (m_wait != 0)) begin n_err++; $display("FAIL late_busy c%0d: got %b want %b", c, bus0.busy, (m_wait != 0)); end
      if (c == 4) begin
        n_vec++; if (bus0.req_ready !== 4'b0010) begin n_err++; $display("FAIL late_grant: got %b want 0010", bus0.req_ready); end
      end
      if (c == 5) begin
        n_vec++; if (bus0.reg_load !== 1'b1 || bus0.reg_data !== 4'b1100) begin n_err++; $display("FAIL late_word: got %b/%b want 1/1100", bus0.reg_load, bus0.reg_data); end
      end
      advance();
      if (c == 0) bus0.req_valid = '0;
      if (c == 1) bus0.req_valid = 4'b0010;
      if (c == 4) bus0.req_valid = '0;
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    bus0.req_valid = 4'b0100;
    bus0.req_data  = {4'b0101, 4'b0011, 4'b1100, 4'b1010};
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      exp_ready = model_ready(bus0.req_valid);
      n_vec++; if (bus0.req_ready !== exp_ready) begin n_err++; $display("FAIL rmid_ready c%0d: got %b want %b", c, bus0.req_ready, exp_ready); end
      n_vec++; if (bus0.reg_load !== m_load) begin n_err++; $display("FAIL rmid_load c%0d: got %b want %b", c, bus0.reg_load, m_load); end
      n_vec++; if (bus0.busy !== (m_wait != 0)) begin n_err++; $display("FAIL rmid_busy c%0d: got %b want %b", c, bus0.busy, (m_wait != 0)); end
      if (c == 3) begin
        n_vec++; if (bus0.req_ready !== 4'b0001 || bus0.busy !== 1'b0) begin n_err++; $display("FAIL rmid_restart: got %b/%b want 0001/0", bus0.req_ready, bus0.busy); end
      end
      advance();
      if (c == 0) bus0.req_valid = '0;
      if (c == 1) begin reset0 = 1'b1; bus0.req_valid = '1; end
      if (c == 2) reset0 = 1'b0;
      if (c == 3) bus0.req_valid = '0;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus0.req_valid = N'($urandom_range(0, (1 << N) - 1));
      bus0.req_data  = (N*W)'($urandom);
      reset0 = ($urandom_range(0, 49) == 0);
      @(negedge clock);
      exp_ready = model_ready(bus0.req_valid);
      n_vec++; if (bus0.req_ready !== exp_ready) begin n_err++; $display("FAIL rand_ready c%0d: got %b want %b", c, bus0.req_ready, exp_ready); end
      n_vec++; if (bus0.reg_load !== m_load) begin n_err++; $display("FAIL rand_load c%0d: got %b want %b", c, bus0.reg_load, m_load); end
      n_vec++; if (bus0.reg_data !== m_data) begin n_err++; $display("FAIL rand_data c%0d: got %b want %b", c, bus0.reg_data, m_data); end
      n_vec++; if (bus0.reg_owner !== 2'(m_owner)) begin n_err++; $display("FAIL rand_owner c%0d: got %0d want %0d", c, bus0.reg_owner, m_owner); end
      n_vec++; if (bus0.busy !== (m_wait != 0)) begin n_err++; $display("FAIL rand_busy c%0d: got %b want %b", c, bus0.busy, (m_wait != 0)); end
      advance();
    end
    reset0 = 1'b0;
    bus0.req_valid = '0;
  endtask

  task automatic test_hold_zero();
    logic exp_rdy;
    logic exp_ld;
    bus1.req_valid = 4'b0001;
    bus1.req_data  = (N*W)'($urandom);
    reset1 = 1'b1;
    @(posedge clock); #1;
    reset1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      exp_rdy = (k % 2 == 0);
      exp_ld  = (k % 2 == 1);
      n_vec++; if (bus1.req_ready !== {3'b000, exp_rdy}) begin n_err++; $display("FAIL h0_ready k%0d: got %b want %b", k, bus1.req_ready, {3'b000, exp_rdy}); end
      n_vec++; if (bus1.reg_load !== exp_ld) begin n_err++; $display("FAIL h0_load k%0d: got %b want %b", k, bus1.reg_load, exp_ld); end
      n_vec++; if ((bus1.req_ready[0] & bus1.reg_load) !== 1'b0) begin n_err++; $display("FAIL h0_overlap k%0d: got 1 want 0", k); end
      if (exp_ld) begin
        n_vec++; if (bus1.reg_data !== bus1.req_data[W-1:0]) begin n_err++; $display("FAIL h0_data k%0d: got %b want %b", k, bus1.reg_data, bus1.req_data[W-1:0]); end
      end
      @(posedge clock); #1;
    end
    bus1.req_valid = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus0.req_valid = '1;
    bus0.req_data  = '0;
    bus1.req_valid = '0;
    bus1.req_data  = '0;
    test_reset();
    test_single();
    test_contention();
    test_late_arrival();
    test_reset_mid_hold();
    test_random();
    test_hold_zero();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
